rng_burst_fill_ram: RTL and testbench

Parametrised dual-port Wishbone RAM with a built-in burst fill engine. The engine writes a programmable run of consecutive words from an external RNG word stream (valid/ready), starting at a programmable base address.
Port A is shared between Wishbone and the fill engine. While a fill runs, Wishbone on port A sees stall; requests are never silently dropped. Port B is an independent Wishbone port.
The block sits between the TRNG word generator and the bus masters. It replaces the single-word RNG write path.

---
 rtl/rng_burst_fill_ram_if.sv | 25 ++
 rtl/rng_burst_fill_ram.sv | 184 ++++++++++++++++++
 tb/tb_rng_burst_fill_ram.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_burst_fill_ram_if.sv
// Wishbone pipelined port bundle for rng_burst_fill_ram.
// master: bus master side; slave: RAM side.
interface rng_burst_fill_ram_if #(
   parameter int DW = 32,
   parameter int AW = 9
) ();
   logic              cyc;
   logic              stb;
   logic [DW/8-1:0]   we;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     wdata;
   logic              ack;
   logic              stall;
   logic [DW-1:0]     rdata;

   modport master (
      output cyc, stb, we, addr, wdata,
      input  ack, stall, rdata
   );

   modport slave (
      input  cyc, stb, we, addr, wdata,
      output ack, stall, rdata
   );
endinterface

// File: rtl/rng_burst_fill_ram.sv
// Dual-port Wishbone RAM with a burst fill engine fed by an RNG word stream.
// Port A is shared with the fill engine and stalls while a fill runs; port B
// is independent. On same-address writes the port A side wins per byte lane.
// Optional macro RNG_REPEAT_CHK_EN: drop and flag an RNG word equal to the
// previous accepted word of the same fill.
//
// state | meaning
// IDLE  | waiting for fill_start_i
// FILL  | accepting RNG words, writing at cur_addr, port A stalled
// DONE  | one-cycle fill_done_o pulse, then IDLE
module rng_burst_fill_ram #(
   parameter int DW = 32,
   parameter int AW = 9,
   parameter int LW = AW + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   rng_burst_fill_ram_if.slave pA,
   rng_burst_fill_ram_if.slave pB,
   input  logic            rng_valid_i,
   input  logic [DW-1:0]   rng_data_i,
   output logic            rng_ready_o,
   input  logic            fill_start_i,
   input  logic [AW-1:0]   fill_base_i,
   input  logic [LW-1:0]   fill_len_i,
   output logic            fill_busy_o,
   output logic            fill_done_o,
   output logic [LW-1:0]   fill_count_o,
   output logic            rng_rep_err_o
);
   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cur_addr_q;
   logic [LW-1:0]   remaining_q;
   logic [LW-1:0]   count_q;

   logic            rng_hs;
   logic            rep_hit;
   logic            fill_wr;
   logic            start_acc;

   logic            a_acc, b_acc;
   logic            wa_en;
   logic [AW-1:0]   wa_addr;
   logic [DW-1:0]   wa_data;
   logic [NB-1:0]   wa_be;

   logic [DW-1:0]   mem [DEPTH];
   logic            a_ack_q, b_ack_q;
   logic [DW-1:0]   a_rdata_q, b_rdata_q;

   assign start_acc = (state_q == IDLE) && fill_start_i;
   assign rng_hs    = rng_valid_i && (state_q == FILL);
   assign fill_wr   = rng_hs && !rep_hit;

`ifdef RNG_REPEAT_CHK_EN
   logic [DW-1:0]   prev_q;
   logic            have_prev_q;
   logic            rep_err_q;

   assign rep_hit       = have_prev_q && (rng_data_i == prev_q);
   assign rng_rep_err_o = rep_err_q;

   // Track the previous accepted word of this fill and the sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         rep_err_q   <= 1'b0;
      end else if (start_acc) begin
         have_prev_q <= 1'b0;
         rep_err_q   <= 1'b0;
      end else if (rng_hs) begin
         prev_q      <= rng_data_i;
         have_prev_q <= 1'b1;
         if (rep_hit)
            rep_err_q <= 1'b1;
      end
   end
`else
   assign rep_hit       = 1'b0;
   assign rng_rep_err_o = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (fill_start_i)
                  state_d = (fill_len_i != '0) ? FILL : DONE;
         FILL: if (fill_wr && (remaining_q == LW'(1)))
                  state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign rng_ready_o  = (state_q == FILL);
   assign fill_busy_o  = (state_q == FILL);
   assign fill_done_o  = (state_q == DONE);
   assign fill_count_o = count_q;

   // Fill address, remaining and count registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cur_addr_q  <= '0;
         remaining_q <= '0;
         count_q     <= '0;
      end else if (start_acc) begin
         cur_addr_q  <= fill_base_i;
         remaining_q <= fill_len_i;
         count_q     <= '0;
      end else if (fill_wr) begin
         cur_addr_q  <= cur_addr_q + AW'(1);
         remaining_q <= remaining_q - LW'(1);
         count_q     <= count_q + LW'(1);
      end
   end

   assign pA.stall = (state_q == FILL);
   assign pB.stall = 1'b0;
   assign a_acc    = pA.cyc && pA.stb && !pA.stall;
   assign b_acc    = pB.cyc && pB.stb;

   // Port A side write source: fill engine while filling, else the bus.
   always_comb begin
      wa_en   = 1'b0;
      wa_addr = pA.addr;
      wa_data = pA.wdata;
      wa_be   = pA.we;
      if (fill_wr) begin
         wa_en   = 1'b1;
         wa_addr = cur_addr_q;
         wa_data = rng_data_i;
         wa_be   = '1;
      end else if (a_acc) begin
         wa_en   = 1'b1;
      end
   end

   // Memory array: port B written first so the port A side overrides lanes.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NB; i++) begin
         if (b_acc && pB.we[i])
            mem[pB.addr][i*8 +: 8] <= pB.wdata[i*8 +: 8];
         if (wa_en && wa_be[i])
            mem[wa_addr][i*8 +: 8] <= wa_data[i*8 +: 8];
      end
   end

   // Registered read-first data and one-cycle acks.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         a_ack_q <= a_acc;
         b_ack_q <= b_acc;
         if (a_acc)
            a_rdata_q <= mem[pA.addr];
         if (b_acc)
            b_rdata_q <= mem[pB.addr];
      end
   end

   assign pA.ack   = a_ack_q;
   assign pB.ack   = b_ack_q;
   assign pA.rdata = a_rdata_q;
   assign pB.rdata = b_rdata_q;
endmodule

// File: tb/tb_rng_burst_fill_ram.sv
// Bench for rng_burst_fill_ram: vector table on the bus ports plus directed
// fill sequences; read data checked through per-port expectation queues.
module tb_rng_burst_fill_ram;
   localparam int DW = 32;
   localparam int AW = 9;
   localparam int LW = AW + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            rng_valid = 1'b0;
   logic [DW-1:0]   rng_data  = '0;
   logic            rng_ready;
   logic            fill_start = 1'b0;
   logic [AW-1:0]   fill_base  = '0;
   logic [LW-1:0]   fill_len   = '0;
   logic            fill_busy, fill_done, rep_err;
   logic [LW-1:0]   fill_count;

   rng_burst_fill_ram_if #(.DW(DW), .AW(AW)) pa ();
   rng_burst_fill_ram_if #(.DW(DW), .AW(AW)) pb ();

   rng_burst_fill_ram #(.DW(DW), .AW(AW), .LW(LW)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pA            (pa),
      .pB            (pb),
      .rng_valid_i   (rng_valid),
      .rng_data_i    (rng_data),
      .rng_ready_o   (rng_ready),
      .fill_start_i  (fill_start),
      .fill_base_i   (fill_base),
      .fill_len_i    (fill_len),
      .fill_busy_o   (fill_busy),
      .fill_done_o   (fill_done),
      .fill_count_o  (fill_count),
      .rng_rep_err_o (rep_err)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          rd;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   typedef struct {
      bit          on_a;
      logic [3:0]  we;
      logic [8:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[5];

   bit a_acc_done;
   bit a_stall_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Ack monitor: every ack consumes one expectation; reads compare data.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
         if (pa.ack) begin
            if (qa.size() == 0) begin
               total++; bad++;
               $display("FAIL pa_spurious_ack: got ack=1 expected no ack");
            end else begin
               e = qa.pop_front();
               if (e.rd) chk({"pa_rdata_", e.name}, pa.rdata, e.exp);
            end
         end
         if (pb.ack) begin
            if (qb.size() == 0) begin
               total++; bad++;
               $display("FAIL pb_spurious_ack: got ack=1 expected no ack");
            end else begin
               e = qb.pop_front();
               if (e.rd) chk({"pb_rdata_", e.name}, pb.rdata, e.exp);
            end
         end
      end
   end

   // All tasks start and end just after a falling edge.
   task automatic b_xfer(input logic [3:0] we, input logic [8:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp, input string name);
      pb.cyc = 1'b1; pb.stb = 1'b1; pb.we = we; pb.addr = addr; pb.wdata = wd;
      qb.push_back('{rd: (we == 4'h0), exp: exp, name: name});
      @(negedge clk);
      chk({"pb_ack_", name}, {31'b0, pb.ack}, 32'd1);
      pb.cyc = 1'b0; pb.stb = 1'b0; pb.we = '0;
   endtask

   task automatic a_xfer(input logic [3:0] we, input logic [8:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp, input string name);
      int n = 0;
      pa.cyc = 1'b1; pa.stb = 1'b1; pa.we = we; pa.addr = addr; pa.wdata = wd;
      a_stall_seen = 1'b0;
      while (pa.stall && n < 200) begin
         a_stall_seen = 1'b1;
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL pa_stall_timeout_%s: stall still 1 after %0d cycles, required 0", name, n);
      end
      a_acc_done = fill_done;
      qa.push_back('{rd: (we == 4'h0), exp: exp, name: name});
      @(negedge clk);
      chk({"pa_ack_", name}, {31'b0, pa.ack}, 32'd1);
      pa.cyc = 1'b0; pa.stb = 1'b0; pa.we = '0;
   endtask

   task automatic start_fill(input logic [8:0] base, input logic [9:0] len);
      fill_start = 1'b1; fill_base = base; fill_len = len;
      @(negedge clk);
      fill_start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap, input string name);
      int n = 0;
      repeat (gap) @(negedge clk);
      chk({"busy_", name}, {31'b0, fill_busy}, 32'd1);
      rng_valid = 1'b1; rng_data = w;
      while (!rng_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL rng_ready_timeout_%s: ready 0 for %0d cycles, required 1", name, n);
      end
      @(negedge clk);
      rng_valid = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] w4 [4];
      pa.cyc = 0; pa.stb = 0; pa.we = 0; pa.addr = 0; pa.wdata = 0;
      pb.cyc = 0; pb.stb = 0; pb.we = 0; pb.addr = 0; pb.wdata = 0;

      tbl[0] = '{on_a: 1'b0, we: 4'hF, addr: 9'h020, wd: 32'hDEADBEEF, exp: 32'hDEADBEEF};
      tbl[1] = '{on_a: 1'b1, we: 4'h1, addr: 9'h020, wd: 32'h000000AA, exp: 32'hDEADBEAA};
      tbl[2] = '{on_a: 1'b0, we: 4'h6, addr: 9'h020, wd: 32'h12345600, exp: 32'hDE3456AA};
      tbl[3] = '{on_a: 1'b1, we: 4'hF, addr: 9'h021, wd: 32'h0BADF00D, exp: 32'h0BADF00D};
      tbl[4] = '{on_a: 1'b0, we: 4'h8, addr: 9'h020, wd: 32'hFF000000, exp: 32'hFF3456AA};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy",  {31'b0, fill_busy}, 0);
      chk("rst_done",  {31'b0, fill_done}, 0);
      chk("rst_ready", {31'b0, rng_ready}, 0);
      chk("rst_count", {22'b0, fill_count}, 0);
      chk("rst_err",   {31'b0, rep_err}, 0);
      chk("rst_pa_ack", {31'b0, pa.ack}, 0);
      chk("rst_pb_ack", {31'b0, pb.ack}, 0);
      chk("rst_pa_stall", {31'b0, pa.stall}, 0);
      chk("rst_pb_stall", {31'b0, pb.stall}, 0);
      chk("rst_pa_rdata", pa.rdata, 0);
      chk("rst_pb_rdata", pb.rdata, 0);

      // Byte-lane vectors: write on one port, read back on the other
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].on_a) begin
            a_xfer(tbl[i].we, tbl[i].addr, tbl[i].wd, 0, $sformatf("vw%0d", i));
            b_xfer(4'h0, tbl[i].addr, 0, tbl[i].exp, $sformatf("vr%0d", i));
         end else begin
            b_xfer(tbl[i].we, tbl[i].addr, tbl[i].wd, 0, $sformatf("vw%0d", i));
            a_xfer(4'h0, tbl[i].addr, 0, tbl[i].exp, $sformatf("vr%0d", i));
         end
      end

      // Fill base 0x010 len 4 with valid gaps
      w4 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      start_fill(9'h010, 10'd4);
      for (int i = 0; i < 4; i++) begin
         send_word(w4[i], i % 2 + 1, $sformatf("f1_%0d", i));
         if (i == 1) chk("f1_count_mid", {22'b0, fill_count}, 2);
      end
      chk("f1_done",  {31'b0, fill_done}, 1);
      chk("f1_busy_done", {31'b0, fill_busy}, 0);
      chk("f1_count", {22'b0, fill_count}, 4);
      @(negedge clk);
      chk("f1_done_once", {31'b0, fill_done}, 0);
      for (int i = 0; i < 4; i++)
         b_xfer(4'h0, 9'h010 + 9'(i), 0, w4[i], $sformatf("f1_rd%0d", i));

      // Back-to-back pipelined port B reads
      pb.cyc = 1'b1; pb.stb = 1'b1; pb.we = 0; pb.addr = 9'h012;
      qb.push_back('{rd: 1'b1, exp: 32'h33333333, name: "b2b0"});
      @(negedge clk);
      pb.addr = 9'h013;
      qb.push_back('{rd: 1'b1, exp: 32'h44444444, name: "b2b1"});
      @(negedge clk);
      chk("b2b_ack1", {31'b0, pb.ack}, 1);
      pb.cyc = 1'b0; pb.stb = 1'b0;
      @(negedge clk);

      // Wrap fill at top of memory
      b_xfer(4'hF, 9'h002, 32'h02020202, 0, "pre002");
      w4 = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4};
      start_fill(9'h1FE, 10'd4);
      for (int i = 0; i < 4; i++)
         send_word(w4[i], 0, $sformatf("wrap_%0d", i));
      chk("wrap_done", {31'b0, fill_done}, 1);
      @(negedge clk);
      b_xfer(4'h0, 9'h1FE, 0, w4[0], "wrap_1fe");
      b_xfer(4'h0, 9'h1FF, 0, w4[1], "wrap_1ff");
      b_xfer(4'h0, 9'h000, 0, w4[2], "wrap_000");
      b_xfer(4'h0, 9'h001, 0, w4[3], "wrap_001");
      b_xfer(4'h0, 9'h002, 0, 32'h02020202, "wrap_002");

      // Port A read stalled by a fill
      start_fill(9'h010, 10'd2);
      fork
         a_xfer(4'h0, 9'h010, 0, 32'h5A5A0001, "stalled");
         begin
            send_word(32'h5A5A0001, 0, "st_0");
            send_word(32'h5A5A0002, 0, "st_1");
         end
      join
      chk("stall_seen", {31'b0, a_stall_seen}, 1);
      chk("accept_in_done", {31'b0, a_acc_done}, 1);
      chk("st_count", {22'b0, fill_count}, 2);

      // Zero-length fill
      start_fill(9'h010, 10'd0);
      chk("z_done",  {31'b0, fill_done}, 1);
      chk("z_ready", {31'b0, rng_ready}, 0);
      chk("z_busy",  {31'b0, fill_busy}, 0);
      @(negedge clk);
      chk("z_done_end", {31'b0, fill_done}, 0);
      b_xfer(4'h0, 9'h010, 0, 32'h5A5A0001, "z_mem");

      // Same-cycle write collision on 0x005
      pa.cyc = 1; pa.stb = 1; pa.we = 4'b0011; pa.addr = 9'h005; pa.wdata = 32'hAABBCCDD;
      pb.cyc = 1; pb.stb = 1; pb.we = 4'b1111; pb.addr = 9'h005; pb.wdata = 32'h11223344;
      qa.push_back('{rd: 1'b0, exp: 0, name: "col"});
      qb.push_back('{rd: 1'b0, exp: 0, name: "col"});
      @(negedge clk);
      chk("col_pa_ack", {31'b0, pa.ack}, 1);
      chk("col_pb_ack", {31'b0, pb.ack}, 1);
      pa.cyc = 0; pa.stb = 0; pa.we = 0;
      pb.cyc = 0; pb.stb = 0; pb.we = 0;
      b_xfer(4'h0, 9'h005, 0, 32'h1122CCDD, "col_rd");

      // Read-first: port A reads while port B writes the same word
      pa.cyc = 1; pa.stb = 1; pa.we = 0; pa.addr = 9'h005;
      pb.cyc = 1; pb.stb = 1; pb.we = 4'hF; pb.addr = 9'h005; pb.wdata = 32'h99999999;
      qa.push_back('{rd: 1'b1, exp: 32'h1122CCDD, name: "rf_old"});
      qb.push_back('{rd: 1'b0, exp: 0, name: "rf_w"});
      @(negedge clk);
      pa.cyc = 0; pa.stb = 0;
      pb.cyc = 0; pb.stb = 0; pb.we = 0;
      a_xfer(4'h0, 9'h005, 0, 32'h99999999, "rf_new");

      // Reset in the middle of a fill
      b_xfer(4'hF, 9'h042, 32'hCAFEF00D, 0, "pre042");
      start_fill(9'h040, 10'd8);
      send_word(32'h71717171, 0, "rs_0");
      send_word(32'h72727272, 0, "rs_1");
      rst = 1'b1;
      @(negedge clk);
      chk("rs_busy",  {31'b0, fill_busy}, 0);
      chk("rs_done",  {31'b0, fill_done}, 0);
      chk("rs_count", {22'b0, fill_count}, 0);
      rst = 1'b0;
      begin
         int pulses = 0;
         repeat (4) begin
            @(negedge clk);
            if (fill_done) pulses++;
         end
         chk("rs_no_done", pulses, 0);
      end
      b_xfer(4'h0, 9'h040, 0, 32'h71717171, "rs_040");
      b_xfer(4'h0, 9'h041, 0, 32'h72727272, "rs_041");
      b_xfer(4'h0, 9'h042, 0, 32'hCAFEF00D, "rs_042");

      // Repeated RNG words
      b_xfer(4'hF, 9'h062, 32'h00000062, 0, "pre062");
      start_fill(9'h060, 10'd2);
`ifdef RNG_REPEAT_CHK_EN
      send_word(32'h5, 0, "rp_0");
      send_word(32'h5, 0, "rp_1");
      chk("rp_count_hold", {22'b0, fill_count}, 1);
      chk("rp_err_set", {31'b0, rep_err}, 1);
      send_word(32'h6, 0, "rp_2");
      chk("rp_done", {31'b0, fill_done}, 1);
      @(negedge clk);
      b_xfer(4'h0, 9'h060, 0, 32'h5, "rp_060");
      b_xfer(4'h0, 9'h061, 0, 32'h6, "rp_061");
      b_xfer(4'h0, 9'h062, 0, 32'h00000062, "rp_062");
      chk("rp_err_sticky", {31'b0, rep_err}, 1);
      start_fill(9'h000, 10'd0);
      chk("rp_err_clear", {31'b0, rep_err}, 0);
      @(negedge clk);
`else
      send_word(32'h5, 0, "rp_0");
      send_word(32'h5, 0, "rp_1");
      chk("rp_done", {31'b0, fill_done}, 1);
      chk("rp_count", {22'b0, fill_count}, 2);
      @(negedge clk);
      b_xfer(4'h0, 9'h060, 0, 32'h5, "rp_060");
      b_xfer(4'h0, 9'h061, 0, 32'h5, "rp_061");
      b_xfer(4'h0, 9'h062, 0, 32'h00000062, "rp_062");
      chk("rp_err_zero", {31'b0, rep_err}, 0);
`endif

      repeat (3) @(negedge clk);
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
